reg_wb_arbiter: RTL and testbench

//   Shares the register file's single write port (IN/INADDRESS/WRITE) between two writeback requesters:
//   ALU results and data-memory load results. MEM has fixed priority. ALU writes that lose arbitration

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wb_queue.sv | 60 ++++++
 rtl/reg_wb_arbiter.sv | 91 +++++++++
 tb/tb_reg_wb_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU writeback definitions: datapath widths, queue entry layout and
// the writeback port grant encoding.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MEM,
    GNT_Q,
    GNT_ALU
  } grant_t;

endpackage

// File: rtl/wb_queue.sv
// Shift-compacting in-order holding queue for ALU writebacks that lost the
// register-file write port. Entry 0 is always the head.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  input  logic                      squash,
  input  logic [ADDR_W-1:0]         squash_addr,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_entry_t      q     [DEPTH];
  wb_entry_t      q_nxt [DEPTH];
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;

  // Survivors of pop/squash are packed toward entry 0 in their original
  // order, then the new push lands right behind the last survivor.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) q_nxt[i] = '0;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q[i].valid && !(pop && i == 0) && !(squash && q[i].addr == squash_addr)) begin
        q_nxt[cnt_nxt[AW-1:0]] = q[i];
        cnt_nxt = cnt_nxt + 1'b1;
      end
    end
    if (push && cnt_nxt < CW'(DEPTH)) begin
      q_nxt[cnt_nxt[AW-1:0]] = '{valid: 1'b1, addr: push_addr, data: push_data};
      cnt_nxt = cnt_nxt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      cnt <= cnt_nxt;
    end
  end

  assign head_addr = q[0].addr;
  assign head_data = q[0].data;
  assign count     = cnt;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register file's single write port between load (MEM, fixed
// priority) and ALU writebacks; losing ALU writes wait in wb_queue.
module reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ALU_REQ,
  input  logic [ADDR_W-1:0]         ALU_ADDR,
  input  logic [DATA_W-1:0]         ALU_DATA,
  input  logic                      MEM_REQ,
  input  logic [ADDR_W-1:0]         MEM_ADDR,
  input  logic [DATA_W-1:0]         MEM_DATA,
  output logic                      RF_WRITE,
  output logic [ADDR_W-1:0]         RF_ADDR,
  output logic [DATA_W-1:0]         RF_DATA,
  output logic                      ALU_STALL,
  output logic [$clog2(DEPTH):0]    PEND_CNT,
  output logic                      ERR_DROP
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  grant_t            grant;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign ALU_STALL = (PEND_CNT == CW'(DEPTH));

  always_comb begin
    grant = GNT_NONE;
    if (MEM_REQ)                grant = GNT_MEM;
    else if (PEND_CNT != '0)    grant = GNT_Q;
    else if (ALU_REQ)           grant = GNT_ALU;
  end

  // A load squashes older queued writes to its register; an ALU write in the
  // same cycle is newer still, so it is enqueued regardless of address.
  assign pop  = (grant == GNT_Q);
  assign push = ALU_REQ && !ALU_STALL && (grant != GNT_ALU);

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK         (CLK),
    .RESET       (RESET),
    .push        (push),
    .push_addr   (ALU_ADDR),
    .push_data   (ALU_DATA),
    .pop         (pop),
    .squash      (MEM_REQ),
    .squash_addr (MEM_ADDR),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (PEND_CNT)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RF_WRITE <= 1'b0;
      RF_ADDR  <= '0;
      RF_DATA  <= '0;
      ERR_DROP <= 1'b0;
    end else begin
      if (ALU_REQ && ALU_STALL) ERR_DROP <= 1'b1;
      unique case (grant)
        GNT_MEM: begin
          RF_WRITE <= 1'b1;
          RF_ADDR  <= MEM_ADDR;
          RF_DATA  <= MEM_DATA;
        end
        GNT_Q: begin
          RF_WRITE <= 1'b1;
          RF_ADDR  <= head_addr;
          RF_DATA  <= head_data;
        end
        GNT_ALU: begin
          RF_WRITE <= 1'b1;
          RF_ADDR  <= ALU_ADDR;
          RF_DATA  <= ALU_DATA;
        end
        default: RF_WRITE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: stimulus queues expected register
// writes, a negedge monitor matches every RF_WRITE against them in order.
module tb_reg_wb_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ALU_REQ;
  logic [2:0] ALU_ADDR;
  logic [7:0] ALU_DATA;
  logic       MEM_REQ;
  logic [2:0] MEM_ADDR;
  logic [7:0] MEM_DATA;
  logic       RF_WRITE;
  logic [2:0] RF_ADDR;
  logic [7:0] RF_DATA;
  logic       ALU_STALL;
  logic [1:0] PEND_CNT;
  logic       ERR_DROP;

  int tests  = 0;
  int failed = 0;
  logic [10:0] sb[$];

  reg_wb_arbiter #(
    .DEPTH (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ALU_REQ   (ALU_REQ),
    .ALU_ADDR  (ALU_ADDR),
    .ALU_DATA  (ALU_DATA),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .RF_WRITE  (RF_WRITE),
    .RF_ADDR   (RF_ADDR),
    .RF_DATA   (RF_DATA),
    .ALU_STALL (ALU_STALL),
    .PEND_CNT  (PEND_CNT),
    .ERR_DROP  (ERR_DROP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [2:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  // Inputs change at negedge; the returned-to negedge follows the sampling posedge.
  task automatic cyc(input logic mr, input logic [2:0] ma, input logic [7:0] md,
                     input logic ar, input logic [2:0] aa, input logic [7:0] ad);
    MEM_REQ = mr; MEM_ADDR = ma; MEM_DATA = md;
    ALU_REQ = ar; ALU_ADDR = aa; ALU_DATA = ad;
    @(negedge CLK);
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (RF_WRITE) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {RF_ADDR, RF_DATA}, 0);
        end else begin
          logic [10:0] e;
          e = sb.pop_front();
          chk("rf_write_addr_data", {RF_ADDR, RF_DATA}, e);
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    cyc(1'b1, 3'd1, 8'hFF, 1'b1, 3'd2, 8'hEE);
    cyc(1'b1, 3'd1, 8'hFF, 1'b1, 3'd2, 8'hEE);
    chk("reset_rf_write", RF_WRITE, 0);
    chk("reset_pend_cnt", PEND_CNT, 0);
    chk("reset_err_drop", ERR_DROP, 0);
    chk("reset_rf_addr_data", {RF_ADDR, RF_DATA}, 0);
    RESET = 1'b0;
    idle();

    // bypass
    expect_wr(3'd3, 8'h2A);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h2A);
    chk("bypass_pend", PEND_CNT, 0);
    idle();
    chk("idle_rf_write", RF_WRITE, 0);
    chk("idle_hold", {RF_ADDR, RF_DATA}, {3'd3, 8'h2A});

    // conflict
    expect_wr(3'd1, 8'h11);
    expect_wr(3'd2, 8'h22);
    cyc(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    chk("conflict_pend1", PEND_CNT, 1);
    idle();
    chk("conflict_pend0", PEND_CNT, 0);
    idle();

    // squash of a queued write by a newer load
    expect_wr(3'd6, 8'h66);
    expect_wr(3'd5, 8'h55);
    cyc(1'b1, 3'd6, 8'h66, 1'b1, 3'd5, 8'hAA);
    chk("squash_pend_before", PEND_CNT, 1);
    cyc(1'b1, 3'd5, 8'h55, 1'b0, 3'd0, 8'h00);
    chk("squash_pend_after", PEND_CNT, 0);
    idle();
    idle();

    // squash the head of a full queue; tail compacts and survives
    expect_wr(3'd0, 8'h01);
    expect_wr(3'd0, 8'h02);
    expect_wr(3'd2, 8'h03);
    expect_wr(3'd4, 8'hA4);
    cyc(1'b1, 3'd0, 8'h01, 1'b1, 3'd2, 8'hA2);
    cyc(1'b1, 3'd0, 8'h02, 1'b1, 3'd4, 8'hA4);
    chk("compact_full", {ALU_STALL, PEND_CNT}, {1'b1, 2'd2});
    cyc(1'b1, 3'd2, 8'h03, 1'b0, 3'd0, 8'h00);
    chk("compact_pend", PEND_CNT, 1);
    idle();
    chk("compact_drain", PEND_CNT, 0);
    chk("no_drop_yet", ERR_DROP, 0);
    idle();

    // full / drop
    expect_wr(3'd7, 8'hB1);
    expect_wr(3'd7, 8'hB2);
    expect_wr(3'd7, 8'hB3);
    expect_wr(3'd3, 8'hC3);
    expect_wr(3'd4, 8'hC4);
    expect_wr(3'd6, 8'hC6);
    cyc(1'b1, 3'd7, 8'hB1, 1'b1, 3'd3, 8'hC3);
    chk("full_step1", {ALU_STALL, PEND_CNT}, {1'b0, 2'd1});
    cyc(1'b1, 3'd7, 8'hB2, 1'b1, 3'd4, 8'hC4);
    chk("full_step2", {ALU_STALL, PEND_CNT}, {1'b1, 2'd2});
    chk("full_no_drop", ERR_DROP, 0);
    cyc(1'b1, 3'd7, 8'hB3, 1'b1, 3'd5, 8'hC5);
    chk("drop_err", ERR_DROP, 1);
    chk("drop_pend", PEND_CNT, 2);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC6);
    chk("drain_drop_pend", PEND_CNT, 1);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC6);
    chk("push_pop_pend", PEND_CNT, 1);
    idle();
    chk("drain_done", PEND_CNT, 0);
    chk("err_sticky", ERR_DROP, 1);
    idle();

    // mid-drain reset
    expect_wr(3'd0, 8'hD0);
    expect_wr(3'd0, 8'hD1);
    cyc(1'b1, 3'd0, 8'hD0, 1'b1, 3'd1, 8'hE1);
    cyc(1'b1, 3'd0, 8'hD1, 1'b1, 3'd2, 8'hE2);
    chk("pre_reset_pend", PEND_CNT, 2);
    RESET = 1'b1;
    idle();
    RESET = 1'b0;
    chk("mid_reset_pend", PEND_CNT, 0);
    chk("mid_reset_err", ERR_DROP, 0);
    chk("mid_reset_rf", {RF_WRITE, RF_ADDR, RF_DATA}, 0);
    idle();
    idle();
    idle();
    chk("post_reset_pend", PEND_CNT, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
